rgb_frame_loader: RTL and testbench
===================================

# rgb_frame_loader

Upstream feeder for the DM163 column mux. Receives a byte stream of RGB data (e.g. from a UART or host bridge) with a valid/ready handshake and packs each 3 bytes into a 24-bit pixel. It writes the 64 pixels of one 8×8 frame to the mux's back buffer at addresses 0..63, then requests a buffer swap by pulsing `send_frame` while the mux reports `ready`.

## Interface
- none. Geometry is fixed: 64 pixels, 24 bits per pixel, 3 bytes per pixel, taken from the shared package.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_data`  in  8  stream byte
- `in_valid`  in  1  `in_data` valid
- `in_sof`  in  1  qualifies the current byte as the first byte of a frame; meaningful only with `in_valid`
- `in_ready`  out  1  loader accepts a byte this cycle
- `mux_ready`  in  1  `ready` from the column mux
- `write_en`  out  1  pixel write strobe to the mux
- `pixel_addr`  out  6  pixel index 0..63
- `pixel_value`  out  24  `{byte0, byte1, byte2}`, i.e. R in [23:16], G in [15:8], B in [7:0]
- `send_frame`  out  1  swap request to the mux
- `frame_err`  out  1  1-cycle pulse on resync
- `frame_count`  out  8  number of frames committed; wraps modulo 256

## Operation
- States: COLLECT, LAST, COMMIT. Reset state is COLLECT.
- Byte acceptance occurs when `in_valid & in_ready`. `in_ready` is 1 only in COLLECT.
- The loader keeps `byte_cnt` (0..2) and `pix_cnt` (0..63). Both reset to 0.
- COLLECT:
  - An accepted byte is stored in slot `byte_cnt`, and `byte_cnt` increments.
  - When the byte in slot 2 is accepted: on the next cycle `write_en`=1, `pixel_addr`=`pix_cnt`, `pixel_value`=packed bytes. `byte_cnt` returns to 0 and `pix_cnt` increments.
  - When that completed pixel is pixel 63, go to LAST on the same edge.
- Resync on `in_sof`:
  - If an accepted byte has `in_sof`=1 while (`byte_cnt`,`pix_cnt`) ≠ (0,0), discard the partial frame and pulse `frame_err` on the next cycle.
  - That byte becomes byte 0 of pixel 0.
  - If `in_sof` arrives with counters at (0,0), there is no error.
  - `in_sof` is optional: frames without it are accepted back-to-back.
- LAST: `write_en` is high for pixel 63. Go to COMMIT unconditionally on the next edge.
- COMMIT:
  - `send_frame` = `mux_ready` (combinational from the state register).
  - When `mux_ready`=1, go to COLLECT with counters at 0 and increment `frame_count`.
  - Otherwise hold in COMMIT indefinitely.
- `write_en` pulses never occur in COMMIT. All 64 writes land at least one edge before `send_frame`.

## Timing
- Reset values: `in_ready`=0 during reset and 1 from the first cycle after release. `write_en`, `send_frame`, `frame_err` = 0. `pixel_addr`, `pixel_value`, `frame_count` = 0.
- Throughput is 1 byte/cycle with no bubbles inside a frame.
- Latency from accepting the third byte of a pixel to `write_en` is 1 cycle.
- `pixel_addr` and `pixel_value` are registered and valid only while `write_en`=1. They hold their last value otherwise.
- End of frame:
  - Byte 191 is accepted at edge E.
  - The LAST cycle, with `write_en` for address 63, follows E.
  - The first COMMIT cycle follows LAST. `send_frame` is high there if `mux_ready`=1.
  - `in_ready` returns to 1 in the cycle after `send_frame`.
- Minimum frame period is 194 cycles.
- `frame_err` and a `write_en` never coincide: a resync byte cannot complete a pixel.
- A reset mid-frame discards all partial data. There is no `send_frame` for the aborted frame.

## Structure
- Shared package `dm163_pkg` holds:
  - `PIXELS_PER_FRAME`=64, `BITS_PER_PIXEL`=24, `PIXEL_ADDR_W`=6, `BYTES_PER_PIXEL`=3
  - a state enum {COLLECT, LAST, COMMIT}
- One natural sub-module is `rgb_byte_packer`. It covers `byte_cnt`, the byte slots, the `in_sof` resync and the `pixel_done` strobe. The top level keeps `pix_cnt`, the FSM and `frame_count`.

## Test plan
- Full frame with `mux_ready`=1:
  - Stimulus: 192 bytes `b[i]=i`, `in_sof` set on the first byte.
  - Response: 64 `write_en` pulses with addr 0..63, where addr 0 = 0x000102 and addr 63 = 0xBDBEBF. Exactly one `send_frame`, 2 cycles after byte 191. `frame_count`=1.
- Commit stall:
  - Stimulus: full frame with `mux_ready`=0 held for 20 cycles after LAST.
  - Response: `in_ready`=0 and `send_frame`=0 throughout. Raising `mux_ready` gives a 1-cycle `send_frame` in that same cycle, and `in_ready`=1 on the next cycle.
- Resync:
  - Stimulus: 100 bytes, then a byte with `in_sof`=1 and value 0xAA, 0xBB, 0xCC.
  - Response: 1-cycle `frame_err`. The next `write_en` has addr 0 and value 0xAABBCC.
- Stream gaps:
  - Stimulus: the same frame as the first scenario with random `in_valid` gaps.
  - Response: an identical write sequence and a single `send_frame`.
- Reset mid-frame:
  - Stimulus: assert `rst_n`=0 after 50 bytes, then send a full frame.
  - Response: all outputs return to their reset values. The first write after release is addr 0. `frame_count`=1 at the end.
- Frame counter wrap:
  - Stimulus: 256 consecutive frames.
  - Response: `frame_count` wraps from 255 to 0, and each frame produces one `send_frame`.

Source files
------------

// File: rtl/dm163_pkg.sv
// Shared geometry and state definitions for the DM163 frame path.
package dm163_pkg;

    localparam int unsigned PIXELS_PER_FRAME = 64;
    localparam int unsigned BITS_PER_PIXEL   = 24;
    localparam int unsigned PIXEL_ADDR_W     = 6;
    localparam int unsigned BYTES_PER_PIXEL  = 3;

    typedef enum logic [1:0] {
        COLLECT,
        LAST,
        COMMIT
    } loader_state_t;

endpackage

// File: rtl/rgb_byte_packer.sv
// Packs accepted stream bytes into 24-bit pixels and handles in_sof resync.
module rgb_byte_packer
    import dm163_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_data,
    input  logic                      accept,
    input  logic                      in_sof,
    input  logic                      pix_zero,
    output logic                      resync,
    output logic                      pixel_done,
    output logic [BITS_PER_PIXEL-1:0] pixel_value,
    output logic                      frame_err
);

    localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_PIXEL - 1);

    logic [1:0] byte_cnt;
    logic [7:0] slot0;
    logic [7:0] slot1;

    // Resync when a start-of-frame byte arrives mid-frame; a resync byte never completes a pixel.
    always_comb begin
        resync     = accept & in_sof & ((byte_cnt != 2'd0) | ~pix_zero);
        pixel_done = accept & ~in_sof & (byte_cnt == LAST_SLOT);
    end

    // Byte slots, slot counter, packed pixel register and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            slot0       <= '0;
            slot1       <= '0;
            pixel_value <= '0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= resync;
            if (accept) begin
                if (resync) begin
                    slot0    <= in_data;
                    byte_cnt <= 2'd1;
                end else begin
                    case (byte_cnt)
                        2'd0: begin
                            slot0    <= in_data;
                            byte_cnt <= 2'd1;
                        end
                        2'd1: begin
                            slot1    <= in_data;
                            byte_cnt <= 2'd2;
                        end
                        default: begin
                            pixel_value <= {slot0, slot1, in_data};
                            byte_cnt    <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/rgb_frame_loader.sv
// Loads one 8x8 RGB frame from a byte stream into the mux back buffer, then requests a swap.
module rgb_frame_loader
    import dm163_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    input  logic                      in_sof,
    output logic                      in_ready,
    input  logic                      mux_ready,
    output logic                      write_en,
    output logic [PIXEL_ADDR_W-1:0]   pixel_addr,
    output logic [BITS_PER_PIXEL-1:0] pixel_value,
    output logic                      send_frame,
    output logic                      frame_err,
    output logic [7:0]                frame_count
);

    localparam logic [PIXEL_ADDR_W-1:0] LAST_PIX = PIXEL_ADDR_W'(PIXELS_PER_FRAME - 1);

    loader_state_t           state;
    loader_state_t           state_next;
    logic [PIXEL_ADDR_W-1:0] pix_cnt;
    logic                    accept;
    logic                    resync;
    logic                    pixel_done;

    assign accept = in_valid & in_ready;

    rgb_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .accept      (accept),
        .in_sof      (in_sof),
        .pix_zero    (pix_cnt == '0),
        .resync      (resync),
        .pixel_done  (pixel_done),
        .pixel_value (pixel_value),
        .frame_err   (frame_err)
    );

    // Next-state and swap request.
    always_comb begin
        state_next = state;
        send_frame = 1'b0;
        case (state)
            COLLECT: if (pixel_done && pix_cnt == LAST_PIX) state_next = LAST;
            LAST:    state_next = COMMIT;
            COMMIT: begin
                send_frame = mux_ready;
                if (mux_ready) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_next;
    end

    // in_ready is registered from the next state so it stays low through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b0;
            pix_cnt     <= '0;
            write_en    <= 1'b0;
            pixel_addr  <= '0;
            frame_count <= '0;
        end else begin
            in_ready <= (state_next == COLLECT);
            write_en <= pixel_done;
            if (pixel_done) pixel_addr <= pix_cnt;
            if (resync || send_frame) pix_cnt <= '0;
            else if (pixel_done)      pix_cnt <= pix_cnt + 1'b1;
            if (send_frame) frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Randomized self-checking bench for rgb_frame_loader against a frame-level reference model.
module tb_rgb_frame_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sof;
    logic        in_ready;
    logic        mux_ready;
    logic        write_en;
    logic [5:0]  pixel_addr;
    logic [23:0] pixel_value;
    logic        send_frame;
    logic        frame_err;
    logic [7:0]  frame_count;

    rgb_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .mux_ready   (mux_ready),
        .write_en    (write_en),
        .pixel_addr  (pixel_addr),
        .pixel_value (pixel_value),
        .send_frame  (send_frame),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a frame is 192 bytes grouped three at a time into pixels 0..63.
    typedef struct {
        logic [5:0]  a;
        logic [23:0] v;
    } wr_t;

    wr_t         exp_wq[$];
    int          mb = 0;
    int          mp = 0;
    logic [7:0]  mslot[3];
    bit          we_due = 0;
    bit          err_due = 0;
    bit          commit_pend = 0;
    int          commit_cyc = 0;
    int          cyc = 0;
    logic [7:0]  exp_fc = 0;
    int          n_sf = 0;
    int          n_ferr = 0;
    logic [23:0] obs_mem[64];
    bit          fresh = 0;
    logic [5:0]  first_addr = 0;

    task automatic model_accept(input logic [7:0] d, input logic s);
        wr_t w;
        if (s && (mb != 0 || mp != 0)) begin
            err_due = 1;
            mb = 0;
            mp = 0;
        end
        mslot[mb] = d;
        mb++;
        if (mb == 3) begin
            w.a = mp[5:0];
            w.v = {mslot[0], mslot[1], mslot[2]};
            exp_wq.push_back(w);
            we_due = 1;
            mb = 0;
            mp++;
            if (mp == 64) begin
                mp = 0;
                commit_pend = 1;
                commit_cyc = cyc + 2;
            end
        end
    endtask

    // Monitor: compare outputs mid-cycle, then feed the byte about to be accepted into the model.
    always @(negedge clk) begin
        bit  exp_sf;
        wr_t ew;
        cyc++;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_write_en", write_en, 0);
            check("rst_send_frame", send_frame, 0);
            check("rst_frame_err", frame_err, 0);
            check("rst_pixel_addr", pixel_addr, 0);
            check("rst_pixel_value", pixel_value, 0);
            check("rst_frame_count", frame_count, 0);
            mb = 0; mp = 0;
            exp_wq.delete();
            we_due = 0; err_due = 0; commit_pend = 0;
            exp_fc = 0;
            fresh = 1;
        end else begin
            check("write_en", write_en, we_due);
            if (write_en && we_due && exp_wq.size() > 0) begin
                ew = exp_wq.pop_front();
                check("pixel_addr", pixel_addr, ew.a);
                check("pixel_value", pixel_value, ew.v);
            end
            if (write_en) begin
                obs_mem[pixel_addr] = pixel_value;
                if (fresh) begin
                    first_addr = pixel_addr;
                    fresh = 0;
                end
            end
            check("frame_err", frame_err, err_due);
            if (frame_err) n_ferr++;
            exp_sf = commit_pend && (cyc >= commit_cyc) && mux_ready;
            check("send_frame", send_frame, exp_sf);
            check("in_ready", in_ready, !commit_pend);
            check("frame_count", frame_count, exp_fc);
            if (send_frame) n_sf++;
            we_due = 0;
            err_due = 0;
            if (exp_sf) begin
                commit_pend = 0;
                exp_fc++;
            end
            if (in_valid && in_ready) model_accept(in_data, in_sof);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s);
        int waited = 0;
        bit ok;
        in_data  = d;
        in_sof   = s;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 2000) begin
                check("drive_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_seq_frame(input bit gaps);
        for (int i = 0; i < 192; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive_byte(8'(i), i == 0);
        end
    endtask

    task automatic wait_commit();
        int waited = 0;
        while (commit_pend && waited < 1000) begin
            idle(1);
            waited++;
        end
        if (commit_pend) check("commit_timeout", 0, 1);
        idle(2);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) obs_mem[i] = 24'hFFFFFF;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sf0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        mux_ready = 1'b1;
        rst_n     = 1'b1;
        clear_mem();
        #1 rst_n = 1'b0;
        idle(3);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full frame, mux ready
        send_seq_frame(0);
        wait_commit();
        check("f1_addr0", obs_mem[0], 24'h000102);
        check("f1_addr63", obs_mem[63], 24'hBDBEBF);
        check("f1_send_count", n_sf, 1);
        check("f1_frame_count", frame_count, 1);

        // Commit stall
        mux_ready = 1'b0;
        send_seq_frame(0);
        idle(22);
        check("stall_send_count", n_sf, 1);
        check("stall_in_ready", in_ready, 0);
        mux_ready = 1'b1;
        wait_commit();
        check("stall_send_after", n_sf, 2);
        check("stall_frame_count", frame_count, 2);

        // Resync mid-frame
        clear_mem();
        for (int i = 0; i < 100; i++) drive_byte(8'($urandom), i == 0);
        drive_byte(8'hAA, 1'b1);
        drive_byte(8'hBB, 1'b0);
        drive_byte(8'hCC, 1'b0);
        for (int i = 3; i < 192; i++) drive_byte(8'($urandom), 1'b0);
        wait_commit();
        check("resync_err_count", n_ferr, 1);
        check("resync_addr0", obs_mem[0], 24'hAABBCC);
        check("resync_send_count", n_sf, 3);

        // Stream gaps
        clear_mem();
        send_seq_frame(1);
        wait_commit();
        check("gaps_addr0", obs_mem[0], 24'h000102);
        check("gaps_addr63", obs_mem[63], 24'hBDBEBF);
        check("gaps_send_count", n_sf, 4);

        // Reset mid-frame
        for (int i = 0; i < 50; i++) drive_byte(8'($urandom), i == 0);
        sf0 = n_sf;
        pulse_reset();
        clear_mem();
        send_seq_frame(0);
        wait_commit();
        check("rstmid_first_addr", first_addr, 0);
        check("rstmid_send_count", n_sf - sf0, 1);
        check("rstmid_frame_count", frame_count, 1);

        // 256 frames: counter wraps back to its start value
        sf0 = n_sf;
        for (int f = 0; f < 256; f++)
            for (int i = 0; i < 192; i++)
                drive_byte(8'($urandom), (i == 0) && ($urandom_range(0, 1) == 1));
        wait_commit();
        check("wrap_send_count", n_sf - sf0, 256);
        check("wrap_frame_count", frame_count, 1);
        check("wrap_err_count", n_ferr, 1);
        check("queue_drained", exp_wq.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
